// File: rtl/control_sequencer.sv
// Microcoded control sequencer for the 8-bit bus CPU: steps T0..T4 per instruction
// and decodes every datapath control line from {step, opcode, flags, halt state}.
//
// state  | meaning
// S_RUN  | stepping through fetch/execute microsteps
// S_HALT | HLT executed; step parked at 0, outputs idle until clr
module control_sequencer #(
    parameter int NUM_STEPS = 5,
    parameter bit EARLY_END = 1'b1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    input  logic [3:0]  opcode,
    input  logic        flag_c,
    input  logic        flag_z,
    output logic [2:0]  step,
    output logic        halted,
    output logic        pc_clr_n,
    output logic        ce,
    output logic        co_n,
    output logic        j_n,
    output logic [11:0] ctrl
);

    localparam logic [11:0] C_MI = 12'b1000_0000_0000;
    localparam logic [11:0] C_RI = 12'b0100_0000_0000;
    localparam logic [11:0] C_RO = 12'b0010_0000_0000;
    localparam logic [11:0] C_II = 12'b0001_0000_0000;
    localparam logic [11:0] C_IO = 12'b0000_1000_0000;
    localparam logic [11:0] C_AI = 12'b0000_0100_0000;
    localparam logic [11:0] C_AO = 12'b0000_0010_0000;
    localparam logic [11:0] C_BI = 12'b0000_0001_0000;
    localparam logic [11:0] C_EO = 12'b0000_0000_1000;
    localparam logic [11:0] C_SU = 12'b0000_0000_0100;
    localparam logic [11:0] C_FI = 12'b0000_0000_0010;
    localparam logic [11:0] C_OI = 12'b0000_0000_0001;

    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    // co and j are kept active-high internally so an all-zero word means idle
    typedef struct packed {
        logic        ce;
        logic        co;
        logic        j;
        logic [11:0] ctrl;
    } uop_t;

    function automatic uop_t decode(input logic [2:0] s, input logic [3:0] op,
                                    input logic fc, input logic fz);
        uop_t u;
        u = '0;
        if (s == 3'd0) begin
            u.co   = 1'b1;
            u.ctrl = C_MI;
        end else if (s == 3'd1) begin
            u.ce   = 1'b1;
            u.ctrl = C_RO | C_II;
        end else begin
            case (op)
                OP_LDA: begin
                    case (s)
                        3'd2:    u.ctrl = C_IO | C_MI;
                        3'd3:    u.ctrl = C_RO | C_AI;
                        default: u.ctrl = '0;
                    endcase
                end
                OP_ADD: begin
                    case (s)
                        3'd2:    u.ctrl = C_IO | C_MI;
                        3'd3:    u.ctrl = C_RO | C_BI;
                        3'd4:    u.ctrl = C_EO | C_AI | C_FI;
                        default: u.ctrl = '0;
                    endcase
                end
                OP_SUB: begin
                    case (s)
                        3'd2:    u.ctrl = C_IO | C_MI;
                        3'd3:    u.ctrl = C_RO | C_BI;
                        3'd4:    u.ctrl = C_EO | C_SU | C_AI | C_FI;
                        default: u.ctrl = '0;
                    endcase
                end
                OP_STA: begin
                    case (s)
                        3'd2:    u.ctrl = C_IO | C_MI;
                        3'd3:    u.ctrl = C_AO | C_RI;
                        default: u.ctrl = '0;
                    endcase
                end
                OP_LDI: begin
                    if (s == 3'd2) u.ctrl = C_IO | C_AI;
                end
                OP_JMP: begin
                    if (s == 3'd2) begin
                        u.ctrl = C_IO;
                        u.j    = 1'b1;
                    end
                end
                OP_JC: begin
                    if (s == 3'd2 && fc) begin
                        u.ctrl = C_IO;
                        u.j    = 1'b1;
                    end
                end
                OP_JZ: begin
                    if (s == 3'd2 && fz) begin
                        u.ctrl = C_IO;
                        u.j    = 1'b1;
                    end
                end
                OP_OUT: begin
                    if (s == 3'd2) u.ctrl = C_AO | C_OI;
                end
                default: u = '0;
            endcase
        end
        return u;
    endfunction

    state_t     state_q, state_d;
    logic [2:0] step_q, step_d;
    uop_t       uop_cur;
    uop_t       uop_out;
    logic       rest_idle;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_RUN;
            step_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        uop_cur = decode(step_q, opcode, flag_c, flag_z);

        // True when nothing after the current step does any work for this opcode
        rest_idle = 1'b1;
        for (int k = 3; k < NUM_STEPS; k++) begin
            if (3'(k) > step_q && decode(3'(k), opcode, flag_c, flag_z) != '0) begin
                rest_idle = 1'b0;
            end
        end

        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            S_RUN: begin
                if (en) begin
                    if (step_q == 3'd2 && opcode == OP_HLT) begin
                        state_d = S_HALT;
                        step_d  = 3'd0;
                    end else if (step_q == LAST_STEP) begin
                        step_d = 3'd0;
                    end else if (EARLY_END && step_q >= 3'd2 && rest_idle) begin
                        step_d = 3'd0;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            S_HALT: begin
                step_d = 3'd0;
            end
            default: begin
                state_d = S_RUN;
                step_d  = 3'd0;
            end
        endcase

        uop_out = (clr || state_q == S_HALT) ? '0 : uop_cur;
    end

    assign step     = step_q;
    assign halted   = (state_q == S_HALT);
    assign pc_clr_n = ~clr;
    assign ce       = uop_out.ce;
    assign co_n     = ~uop_out.co;
    assign j_n      = ~uop_out.j;
    assign ctrl     = uop_out.ctrl;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios plus randomized instruction streams
// checked against a per-instruction microprogram model.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr, en, flag_c, flag_z;
    logic [3:0]  opcode;
    logic [2:0]  step;
    logic        halted, pc_clr_n, ce, co_n, j_n;
    logic [11:0] ctrl;

    int tests_run    = 0;
    int tests_failed = 0;

    control_sequencer dut (
        .clk(clk), .clr(clr), .en(en), .opcode(opcode), .flag_c(flag_c), .flag_z(flag_z),
        .step(step), .halted(halted), .pc_clr_n(pc_clr_n), .ce(ce), .co_n(co_n),
        .j_n(j_n), .ctrl(ctrl)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] MI = 12'h800, RI = 12'h400, RO = 12'h200, II = 12'h100;
    localparam logic [11:0] IO = 12'h080, AI = 12'h040, AO = 12'h020, BI = 12'h010;
    localparam logic [11:0] EO = 12'h008, SU = 12'h004, FI = 12'h002, OI = 12'h001;

    // word = {ce, co_n, j_n, ctrl}
    function automatic logic [14:0] w(input logic c_e, input logic pc_out, input logic jump,
                                      input logic [11:0] c);
        return {c_e, ~pc_out, ~jump, c};
    endfunction

    localparam logic [14:0] IDLE = {1'b0, 1'b1, 1'b1, 12'h000};
    localparam logic [14:0] F0   = {1'b0, 1'b0, 1'b1, 12'h800};
    localparam logic [14:0] F1   = {1'b1, 1'b1, 1'b1, 12'h300};

    function automatic logic [18:0] ex(input logic [2:0] s, input logic h, input logic [14:0] wd);
        return {s, h, wd};
    endfunction

    function automatic logic [18:0] obs();
        return {step, halted, ce, co_n, j_n, ctrl};
    endfunction

    function automatic logic inv_ok();
        int drivers;
        drivers = int'(!co_n) + int'(ctrl[9]) + int'(ctrl[7]) + int'(ctrl[5]) + int'(ctrl[3]);
        return (drivers <= 1) && !(!j_n && ce);
    endfunction

    // Microprogram of one instruction: fetch words then the non-idle execute words.
    // Trailing idle steps are skipped, but T2 is always visited.
    logic [14:0] exp_prog [5];
    int          exp_len;

    task automatic load_program(input logic [3:0] op, input logic fc, input logic fz);
        logic [14:0] exq [$];
        case (op)
            4'b0001: exq = '{w(0,0,0,IO|MI), w(0,0,0,RO|AI)};
            4'b0010: exq = '{w(0,0,0,IO|MI), w(0,0,0,RO|BI), w(0,0,0,EO|AI|FI)};
            4'b0011: exq = '{w(0,0,0,IO|MI), w(0,0,0,RO|BI), w(0,0,0,EO|SU|AI|FI)};
            4'b0100: exq = '{w(0,0,0,IO|MI), w(0,0,0,AO|RI)};
            4'b0101: exq = '{w(0,0,0,IO|AI)};
            4'b0110: exq = '{w(0,0,1,IO)};
            4'b0111: if (fc) exq = '{w(0,0,1,IO)};
            4'b1000: if (fz) exq = '{w(0,0,1,IO)};
            4'b1110: exq = '{w(0,0,0,AO|OI)};
            default: exq.delete();
        endcase
        for (int i = 0; i < 5; i++) exp_prog[i] = IDLE;
        exp_prog[0] = F0;
        exp_prog[1] = F1;
        foreach (exq[i]) exp_prog[i+2] = exq[i];
        exp_len = (exq.size() == 0) ? 3 : 2 + exq.size();
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        en  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; en = 1'b1; opcode = 4'b0010; flag_c = 1'b0; flag_z = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            tests_run++;
            if (obs() !== ex(0, 0, IDLE) || pc_clr_n !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold cyc%0d: got %h pc_clr_n=%b want %h pc_clr_n=0",
                         i, obs(), pc_clr_n, ex(0, 0, IDLE));
            end
        end
        clr = 1'b0;
        #1;
        tests_run++;
        if (obs() !== ex(0, 0, F0) || pc_clr_n !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release: got %h pc_clr_n=%b want %h pc_clr_n=1",
                     obs(), pc_clr_n, ex(0, 0, F0));
        end
    endtask

    task automatic test_add();
        logic [14:0] seq [6];
        logic [2:0]  stp [6];
        seq = '{F0, F1, w(0,0,0,IO|MI), w(0,0,0,RO|BI), w(0,0,0,EO|AI|FI), F0};
        stp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        opcode = 4'b0010;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin @(posedge clk); @(negedge clk); #1; end
            tests_run++;
            if (obs() !== ex(stp[i], 0, seq[i]) || !inv_ok()) begin
                tests_failed++;
                $display("FAIL add_seq cyc%0d: got %h want %h inv=%b", i, obs(),
                         ex(stp[i], 0, seq[i]), inv_ok());
            end
        end
    endtask

    task automatic test_jc();
        logic [14:0] seq [7];
        logic [2:0]  stp [7];
        seq = '{F0, F1, IDLE, F0, F1, w(0,0,1,IO), F0};
        stp = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};
        opcode = 4'b0111; flag_c = 1'b0; flag_z = 1'b1;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin @(posedge clk); @(negedge clk); #1; end
            tests_run++;
            if (obs() !== ex(stp[i], 0, seq[i])) begin
                tests_failed++;
                $display("FAIL jc cyc%0d fc=%b: got %h want %h", i, flag_c, obs(),
                         ex(stp[i], 0, seq[i]));
            end
            if (i == 3) flag_c = 1'b1;
        end
        flag_c = 1'b0; flag_z = 1'b0;
    endtask

    task automatic test_hlt();
        opcode = 4'b1111;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            logic [18:0] want;
            if (i > 0) begin @(posedge clk); @(negedge clk); #1; end
            want = (i == 0) ? ex(0, 0, F0) : (i == 1) ? ex(1, 0, F1) :
                   (i == 2) ? ex(2, 0, IDLE) : ex(0, 1, IDLE);
            tests_run++;
            if (obs() !== want) begin
                tests_failed++;
                $display("FAIL hlt cyc%0d: got %h want %h", i, obs(), want);
            end
        end
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        #1;
        tests_run++;
        if (obs() !== ex(0, 0, F0)) begin
            tests_failed++;
            $display("FAIL hlt_exit_t0: got %h want %h", obs(), ex(0, 0, F0));
        end
        @(posedge clk); @(negedge clk); #1;
        tests_run++;
        if (obs() !== ex(1, 0, F1)) begin
            tests_failed++;
            $display("FAIL hlt_exit_t1: got %h want %h", obs(), ex(1, 0, F1));
        end
    endtask

    task automatic test_en_hold();
        logic [14:0] seq [8];
        logic [2:0]  stp [8];
        seq = '{F0, F1, w(0,0,0,IO|MI), w(0,0,0,RO|AI), w(0,0,0,RO|AI),
                w(0,0,0,RO|AI), w(0,0,0,RO|AI), F0};
        stp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0};
        opcode = 4'b0001;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin @(posedge clk); @(negedge clk); #1; end
            tests_run++;
            if (obs() !== ex(stp[i], 0, seq[i])) begin
                tests_failed++;
                $display("FAIL en_hold cyc%0d en=%b: got %h want %h", i, en, obs(),
                         ex(stp[i], 0, seq[i]));
            end
            en = (i >= 3 && i < 6) ? 1'b0 : 1'b1;
        end
        en = 1'b1;
    endtask

    task automatic test_clr_mid_sub();
        opcode = 4'b0011;
        do_reset();
        repeat (3) begin @(posedge clk); @(negedge clk); end
        #1;
        tests_run++;
        if (obs() !== ex(3, 0, w(0,0,0,RO|BI))) begin
            tests_failed++;
            $display("FAIL sub_t3: got %h want %h", obs(), ex(3, 0, w(0,0,0,RO|BI)));
        end
        clr = 1'b1;
        #1;
        tests_run++;
        if (obs() !== ex(3, 0, IDLE) || pc_clr_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL sub_clr_comb: got %h pc_clr_n=%b want %h", obs(), pc_clr_n,
                     ex(3, 0, IDLE));
        end
        @(posedge clk); @(negedge clk); #1;
        tests_run++;
        if (obs() !== ex(0, 0, IDLE)) begin
            tests_failed++;
            $display("FAIL sub_clr_edge: got %h want %h", obs(), ex(0, 0, IDLE));
        end
        clr = 1'b0;
        #1;
        tests_run++;
        if (obs() !== ex(0, 0, F0)) begin
            tests_failed++;
            $display("FAIL sub_clr_resume: got %h want %h", obs(), ex(0, 0, F0));
        end
    endtask

    task automatic test_random();
        int          idx = 0;
        logic        m_halt = 1'b0;
        logic [3:0]  op = 4'h0;
        logic        fc = 1'b0, fz = 1'b0;
        logic [18:0] want;
        do_reset();
        load_program(op, fc, fz);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (idx == 0 && !m_halt) begin
                op = 4'($urandom_range(0, 15));
                fc = 1'($urandom_range(0, 1));
                fz = 1'($urandom_range(0, 1));
                load_program(op, fc, fz);
            end
            clr    = ($urandom_range(0, 59) == 0) || (m_halt && $urandom_range(0, 3) == 0);
            en     = ($urandom_range(0, 3) != 0);
            opcode = op; flag_c = fc; flag_z = fz;
            #1;
            if (m_halt)   want = ex(0, 1, IDLE);
            else if (clr) want = ex(3'(idx), 0, IDLE);
            else          want = ex(3'(idx), 0, exp_prog[idx]);
            tests_run++;
            if (obs() !== want || !inv_ok()) begin
                tests_failed++;
                $display("FAIL random cyc%0d op=%h fc=%b fz=%b clr=%b: got %h want %h inv=%b",
                         cyc, op, fc, fz, clr, obs(), want, inv_ok());
            end
            @(posedge clk);
            if (clr) begin
                idx = 0; m_halt = 1'b0;
            end else if (!m_halt && en) begin
                if (op == 4'b1111 && idx == 2) begin
                    m_halt = 1'b1; idx = 0;
                end else begin
                    idx++;
                    if (idx == exp_len) idx = 0;
                end
            end
            @(negedge clk);
        end
        clr = 1'b0; en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_jc();
        test_hlt();
        test_en_hold();
        test_clr_mid_sub();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
